// File: rtl/mod_arith_pkg.sv
// mod_arith_pkg: shared opcode enum and limb-width helper for modular add/sub pipelines
package mod_arith_pkg;
  typedef enum logic {OP_ADD = 1'b0, OP_SUB = 1'b1} op_e;
  function automatic int limb_w(input int bits, input int level);
    return (bits + level - 1) / level;
  endfunction
endpackage

// File: rtl/mod_addsub_stage.sv
// mod_addsub_stage: one limb of the modular add/sub pipe, plain and P-corrected candidates
// Ports: aclk/areset clock and async reset; en_i loads the stage; vld/op/a/b travel with the beat;
// pl/co are the plain and corrected partial results, cp/cc their carry/borrow into the next limb.
module mod_addsub_stage
  import mod_arith_pkg::*;
#(
  parameter int P    = 100,
  parameter int W    = 7,
  parameter int LIMB = 7,
  parameter int G    = 0
) (
  input  logic         aclk,
  input  logic         areset,
  input  logic         en_i,
  input  logic         vld_i,
  input  op_e          op_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] pl_i,
  input  logic [W-1:0] co_i,
  input  logic         cp_i,
  input  logic         cc_i,
  output logic         vld_o,
  output op_e          op_o,
  output logic [W-1:0] a_o,
  output logic [W-1:0] b_o,
  output logic [W-1:0] pl_o,
  output logic [W-1:0] co_o,
  output logic         cp_o,
  output logic         cc_o
);
  localparam logic [W-1:0] PV = W'(P);
  logic [LIMB-1:0] al, bl, ql;
  logic [LIMB:0] raw, cor;
  logic [W-1:0] pl_d, co_d;
  logic vld_q, cp_q, cc_q;
  op_e op_q;
  logic [W-1:0] a_q, b_q, pl_q, co_q;
  // The corrected chain works on the plain limb, so across all limbs it forms
  // exactly (a op b) -/+ P over the padded width.
  always_comb begin
    al = a_i[G*LIMB +: LIMB];
    bl = b_i[G*LIMB +: LIMB];
    ql = PV[G*LIMB +: LIMB];
    raw = op_i == OP_SUB ? {1'b0, al} - {1'b0, bl} - {{LIMB{1'b0}}, cp_i}
                         : {1'b0, al} + {1'b0, bl} + {{LIMB{1'b0}}, cp_i};
    cor = op_i == OP_SUB ? {1'b0, raw[LIMB-1:0]} + {1'b0, ql} + {{LIMB{1'b0}}, cc_i}
                         : {1'b0, raw[LIMB-1:0]} - {1'b0, ql} - {{LIMB{1'b0}}, cc_i};
    pl_d = pl_i;
    pl_d[G*LIMB +: LIMB] = raw[LIMB-1:0];
    co_d = co_i;
    co_d[G*LIMB +: LIMB] = cor[LIMB-1:0];
  end
  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      vld_q <= 1'b0;
      op_q  <= OP_ADD;
      a_q   <= '0;
      b_q   <= '0;
      pl_q  <= '0;
      co_q  <= '0;
      cp_q  <= 1'b0;
      cc_q  <= 1'b0;
    end else if (en_i) begin
      vld_q <= vld_i;
      op_q  <= op_i;
      a_q   <= a_i;
      b_q   <= b_i;
      pl_q  <= pl_d;
      co_q  <= co_d;
      cp_q  <= raw[LIMB];
      cc_q  <= cor[LIMB];
    end
  assign vld_o = vld_q;
  assign op_o  = op_q;
  assign a_o   = a_q;
  assign b_o   = b_q;
  assign pl_o  = pl_q;
  assign co_o  = co_q;
  assign cp_o  = cp_q;
  assign cc_o  = cc_q;
endmodule

// File: rtl/mod_addsub_pipe.sv
// mod_addsub_pipe: LEVEL-stage pipelined (a op b) mod P with valid/ready handshake
// Ports: aclk, areset (async, active-high); s_tvalid/s_tready/s_tdata_a/s_tdata_b/s_op input beat;
// m_tvalid/m_tready/m_tdata result beat. s_tctl/m_tctl sideband exists only with MOD_ADDSUB_CTL_EN.
module mod_addsub_pipe
  import mod_arith_pkg::*;
#(
  parameter int P        = 100,
  parameter int BITS     = $clog2(P),
  parameter int LEVEL    = 1,
  parameter int CTL_BITS = 8
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic                s_tvalid,
  input  logic [BITS-1:0]     s_tdata_a,
  input  logic [BITS-1:0]     s_tdata_b,
  input  logic                s_op,
`ifdef MOD_ADDSUB_CTL_EN
  input  logic [CTL_BITS-1:0] s_tctl,
  output logic [CTL_BITS-1:0] m_tctl,
`endif
  output logic                s_tready,
  output logic                m_tvalid,
  output logic [BITS-1:0]     m_tdata,
  input  logic                m_tready
);
  localparam int LIMB = limb_w(BITS, LEVEL);
  localparam int W    = LIMB * LEVEL;
  logic [LEVEL:0] vld, cp_s, cc_s;
  logic [LEVEL-1:0] adv;
  op_e op_s [LEVEL+1];
  logic [W-1:0] a_s [LEVEL+1];
  logic [W-1:0] b_s [LEVEL+1];
  logic [W-1:0] pl_s [LEVEL+1];
  logic [W-1:0] co_s [LEVEL+1];
  logic sel, unused_ok;
  assign vld[0]  = s_tvalid;
  assign op_s[0] = op_e'(s_op);
  assign a_s[0]  = W'(s_tdata_a);
  assign b_s[0]  = W'(s_tdata_b);
  assign pl_s[0] = '0;
  assign co_s[0] = '0;
  assign cp_s[0] = 1'b0;
  assign cc_s[0] = 1'b0;
  for (genvar g = 0; g < LEVEL; g++) begin : g_stage
    // Stage g may load when some later stage is empty or the output is taken.
    assign adv[g] = m_tready || !(&vld[LEVEL:g+1]);
    mod_addsub_stage #(.P(P), .W(W), .LIMB(LIMB), .G(g)) u_stage (
      .aclk  (aclk),
      .areset(areset),
      .en_i  (adv[g]),
      .vld_i (vld[g]),
      .op_i  (op_s[g]),
      .a_i   (a_s[g]),
      .b_i   (b_s[g]),
      .pl_i  (pl_s[g]),
      .co_i  (co_s[g]),
      .cp_i  (cp_s[g]),
      .cc_i  (cc_s[g]),
      .vld_o (vld[g+1]),
      .op_o  (op_s[g+1]),
      .a_o   (a_s[g+1]),
      .b_o   (b_s[g+1]),
      .pl_o  (pl_s[g+1]),
      .co_o  (co_s[g+1]),
      .cp_o  (cp_s[g+1]),
      .cc_o  (cc_s[g+1])
    );
  end
  // Add: corrected when the sum carried out or subtracting P did not borrow.
  // Sub: corrected when a-b borrowed.
  assign sel       = op_s[LEVEL] == OP_SUB ? cp_s[LEVEL] : cp_s[LEVEL] | ~cc_s[LEVEL];
  assign s_tready  = adv[0];
  assign m_tvalid  = vld[LEVEL];
  assign m_tdata   = sel ? co_s[LEVEL][BITS-1:0] : pl_s[LEVEL][BITS-1:0];
  assign unused_ok = ^{a_s[LEVEL], b_s[LEVEL], pl_s[LEVEL], co_s[LEVEL]};
`ifdef MOD_ADDSUB_CTL_EN
  logic [CTL_BITS-1:0] ctl_q [LEVEL];
  always_ff @(posedge aclk or posedge areset)
    if (areset) for (int i = 0; i < LEVEL; i++) ctl_q[i] <= '0;
    else begin
      if (adv[0]) ctl_q[0] <= s_tctl;
      for (int i = 1; i < LEVEL; i++) if (adv[i]) ctl_q[i] <= ctl_q[i-1];
    end
  assign m_tctl = ctl_q[LEVEL-1];
`endif
endmodule

// File: tb/tb_mod_addsub_pipe.sv
// tb_mod_addsub_pipe: scoreboard bench for mod_addsub_pipe (P=97, LEVEL=3 plus a LEVEL=1 instance)
module tb_mod_addsub_pipe;
  localparam int P = 97;
  localparam int BITS = 7;
  localparam int LEVEL = 3;
  typedef struct {int data; int ctl; int cyc; bit lat;} exp_t;
  logic clk = 1'b0;
  logic rst;
  logic s_tvalid, s_op, s_tready, m_tvalid, m_tready;
  logic [BITS-1:0] s_tdata_a, s_tdata_b, m_tdata;
  logic s1_tvalid, s1_op, s1_tready, m1_tvalid, m1_tready;
  logic [BITS-1:0] s1_tdata_a, s1_tdata_b, m1_tdata;
`ifdef MOD_ADDSUB_CTL_EN
  logic [7:0] s_tctl, m_tctl, s1_tctl, m1_tctl;
`endif
  exp_t sb[$];
  int checks = 0, passes = 0, cyc = 0, lo_until = 0, prev_data = 0;
  int rmode = 0;
  bit lat_chk = 0, prev_stall = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  mod_addsub_pipe #(.P(P), .BITS(BITS), .LEVEL(LEVEL), .CTL_BITS(8)) dut (
    .aclk(clk), .areset(rst), .s_tvalid(s_tvalid), .s_tdata_a(s_tdata_a), .s_tdata_b(s_tdata_b),
    .s_op(s_op),
`ifdef MOD_ADDSUB_CTL_EN
    .s_tctl(s_tctl), .m_tctl(m_tctl),
`endif
    .s_tready(s_tready), .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tready(m_tready));

  mod_addsub_pipe #(.P(P), .BITS(BITS), .LEVEL(1), .CTL_BITS(8)) dut1 (
    .aclk(clk), .areset(rst), .s_tvalid(s1_tvalid), .s_tdata_a(s1_tdata_a), .s_tdata_b(s1_tdata_b),
    .s_op(s1_op),
`ifdef MOD_ADDSUB_CTL_EN
    .s_tctl(s1_tctl), .m_tctl(m1_tctl),
`endif
    .s_tready(s1_tready), .m_tvalid(m1_tvalid), .m_tdata(m1_tdata), .m_tready(m1_tready));

  function automatic int model(input int a, input int b, input bit op);
    return op ? (a - b + P) % P : (a + b) % P;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Downstream ready: 0 always high, 1 always low, 2 random, 3 low until cycle lo_until.
  always @(negedge clk)
    m_tready = rmode == 0 ? 1'b1 : rmode == 1 ? 1'b0 : rmode == 2 ? ($urandom_range(0, 3) != 0) : (cyc >= lo_until);

  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rst) prev_stall = 0;
    else begin
      if (prev_stall) begin
        chk("hold_valid", int'(m_tvalid), 1);
        chk("hold_data", int'(m_tdata), prev_data);
      end
      prev_stall = m_tvalid && !m_tready;
      prev_data = int'(m_tdata);
      if (m_tvalid && m_tready) begin
        if (sb.size() == 0) chk("unexpected_beat", int'(m_tdata), -1);
        else begin
          e = sb.pop_front();
          chk("result", int'(m_tdata), e.data);
          if (e.lat) chk("latency", cyc, e.cyc);
`ifdef MOD_ADDSUB_CTL_EN
          chk("ctl", int'(m_tctl), e.ctl);
`endif
        end
      end
    end
  end

  task automatic send(input int a, input int b, input bit op, input int ctl);
    int n;
    @(negedge clk);
    s_tvalid = 1'b1;
    s_tdata_a = BITS'(a);
    s_tdata_b = BITS'(b);
    s_op = op;
`ifdef MOD_ADDSUB_CTL_EN
    s_tctl = 8'(ctl);
`endif
    #2;
    n = 0;
    while (!s_tready && n < 200) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (lat_chk) chk("no_bubble", n, 0);
    if (!s_tready) chk("accept_timeout", 0, 1);
    else sb.push_back('{model(a, b, op), ctl & 'hFF, cyc + LEVEL, lat_chk});
    @(posedge clk);
    #1 s_tvalid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sb.size(), 0);
  endtask

  task automatic send_rand();
    send(int'($urandom_range(0, P - 1)), int'($urandom_range(0, P - 1)), 1'($urandom_range(0, 1)),
         int'($urandom_range(0, 255)));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    m_tready = 1'b1;
    s_tvalid = 1'b0; s_op = 1'b0; s_tdata_a = '0; s_tdata_b = '0;
    s1_tvalid = 1'b0; s1_op = 1'b0; s1_tdata_a = '0; s1_tdata_b = '0; m1_tready = 1'b1;
`ifdef MOD_ADDSUB_CTL_EN
    s_tctl = '0; s1_tctl = '0;
`endif
    #1;
    chk("reset_valid", int'(m_tvalid), 0);
    chk("reset_data", int'(m_tdata), 0);
    chk("reset_valid_l1", int'(m1_tvalid), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 chk("ready_after_reset", int'(s_tready), 1);
    lat_chk = 1;
    send(60, 50, 0, 1);
    send(96, 96, 0, 2);
    send(10, 20, 1, 3);
    send(5, 5, 1, 4);
    send(1, 2, 0, 'hA5);
    for (int i = 0; i < 8; i++)
      send(int'($urandom_range(0, P - 1)), int'($urandom_range(0, P - 1)), 1'(i), int'($urandom_range(0, 255)));
    lat_chk = 0;
    drain();
    @(posedge clk);
    #1 lo_until = cyc + 5;
    rmode = 3;
    repeat (3) send_rand();
    @(negedge clk);
    #2 chk("stall_ready_low", int'(s_tready), 0);
    chk("stall_valid", int'(m_tvalid), 1);
    repeat (3) send_rand();
    drain();
    rmode = 2;
    repeat (40) send_rand();
    drain();
    @(posedge clk);
    #1 rmode = 1;
    send(60, 50, 0, 9);
    send(10, 20, 1, 8);
    @(posedge clk);
    #2 chk("inflight_valid", int'(m_tvalid), 1);
    rst = 1'b1;
    #1 chk("async_reset_valid", int'(m_tvalid), 0);
    chk("async_reset_data", int'(m_tdata), 0);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("ready_after_midreset", int'(s_tready), 1);
    @(posedge clk);
    #1 rmode = 0;
    repeat (6) @(negedge clk);
    #3 chk("no_stale_valid", int'(m_tvalid), 0);
    lat_chk = 1;
    send(96, 96, 0, 7);
    lat_chk = 0;
    drain();
    @(negedge clk);
    s1_tvalid = 1'b1; s1_tdata_a = 7'd60; s1_tdata_b = 7'd50; s1_op = 1'b0;
    #2 chk("l1_ready", int'(s1_tready), 1);
    chk("l1_pre_valid", int'(m1_tvalid), 0);
    @(posedge clk);
    #1 s1_tvalid = 1'b0;
    @(negedge clk);
    #2 chk("l1_valid", int'(m1_tvalid), 1);
    chk("l1_data", int'(m1_tdata), 13);
    @(negedge clk);
    #2 chk("l1_empty", int'(m1_tvalid), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/mod_addsub_pipe.md
MOD_ADDSUB_PIPE -- requirements
Module: mod_addsub_pipe

Interface
REQ-001 SHALL have parameter P, default 100: modulus, P >= 2.
REQ-002 SHALL have parameter BITS, default $clog2(P): operand/result width.
REQ-003 SHALL have parameter LEVEL, default 1: pipeline stages/limbs, 1 <= LEVEL <= BITS.
REQ-004 SHALL have parameter CTL_BITS, default 8: sideband width.
REQ-005 SHALL have port aclk, input, 1: sole clock, rising edge.
REQ-006 SHALL have port areset, input, 1: reset, asynchronous, active-high.
REQ-007 SHALL have port s_tvalid, input, 1: operand beat valid.
REQ-008 SHALL have port s_tdata_a, input, BITS: operand a.
REQ-009 SHALL have port s_tdata_b, input, BITS: operand b.
REQ-010 SHALL have port s_op, input, 1: 0 = add, 1 = subtract; sampled per beat.
REQ-011 SHALL have port s_tctl, input, CTL_BITS: sideband; present only with MOD_ADDSUB_CTL_EN.
REQ-012 SHALL have port s_tready, output, 1: upstream may transfer.
REQ-013 SHALL have port m_tvalid, output, 1: result valid.
REQ-014 SHALL have port m_tdata, output, BITS: (a op b) mod P.
REQ-015 SHALL have port m_tctl, output, CTL_BITS: sideband aligned with m_tdata; present only with MOD_ADDSUB_CTL_EN.
REQ-016 SHALL have port m_tready, input, 1: downstream accepts.

Function
REQ-017 SHALL take operands a, b < P; results for out-of-range operands are unspecified.
REQ-018 SHALL, for add, output a+b-P if a+b >= P, else a+b.
REQ-019 SHALL, for subtract, output a-b+P if a < b, else a-b.
REQ-020 SHALL split operands into LEVEL limbs of LIMB = ceil(BITS/LEVEL) bits, zero-padded at the top; stage g processes limb g, LSB first.
REQ-021 SHALL, per stage, compute two candidates (plain and P-corrected), each with its own carry/borrow registered into the next stage.
REQ-022 SHALL select the final result from the last stage's carry/borrow: add picks the corrected candidate when a+b >= P; subtract picks the corrected candidate when the raw borrow is set.
REQ-023 SHALL transfer a beat on s_tvalid && s_tready, and emit it on m_tvalid && m_tready.
REQ-024 SHALL have a latency of exactly LEVEL cycles from accept to m_tvalid when m_tready is held high.
REQ-025 SHALL sustain 1 beat/cycle under continuous m_tready.
REQ-026 SHALL advance stage g when stage g+1 is empty or stage g+1 advances; s_tready SHALL equal stage-0 advance.
REQ-027 SHALL hold m_tdata, m_tctl and m_tvalid stable while m_tvalid && !m_tready.
REQ-028 SHALL preserve beat order, and SHALL neither drop nor duplicate beats under any m_tready pattern.
REQ-029 SHALL allow s_op to differ on every beat with no bubble.
REQ-030 SHALL let s_tready depend combinationally on m_tready only through the stage-ready chain; s_tready SHALL NOT depend on s_tvalid.

Reset
REQ-031 SHALL, on areset assertion, immediately clear all stage valids: m_tvalid = 0, m_tdata = 0, m_tctl = 0.
REQ-032 SHALL discard in-flight beats on reset mid-operation; the first beat after reset release SHALL see an empty pipe, with s_tready = 1.

Configuration
REQ-033 SHALL, with MOD_ADDSUB_CTL_EN defined, carry s_tctl through every stage alongside its beat.
REQ-034 SHALL, without MOD_ADDSUB_CTL_EN, have no ctl ports and no ctl registers; all other behaviour is unchanged.

Structure
REQ-035 SHALL place in package mod_arith_pkg: op enum (OP_ADD = 0, OP_SUB = 1) and the limb-width function ceil(BITS/LEVEL).
REQ-036 SHALL implement one limb stage as sub-module mod_addsub_stage, instantiated LEVEL times by generate.

Verification (P=97, BITS=7, LEVEL=3, LIMB=3)
REQ-037 SHALL cover: add 60+50, m_tready = 1 -> m_tdata = 13 exactly 3 cycles after accept; add 96+96 -> 95.
REQ-038 SHALL cover: sub 10-20 -> 87; sub 5-5 -> 0; alternating add/sub back-to-back beats -> correct per-beat results with no bubbles.
REQ-039 SHALL cover: 6 beats streamed, m_tready low 5 cycles -> s_tready falls once 3 beats are held, m_tdata stable, all 6 results in order, none lost.
REQ-040 SHALL cover: areset pulsed with 2 beats in flight -> m_tvalid = 0 same cycle, no stale beats after release.
REQ-041 SHALL cover: with MOD_ADDSUB_CTL_EN, ctl 0xA5 on add 1+2 -> m_tctl = 0xA5 with m_tdata = 3.
REQ-042 SHALL cover: LEVEL = 1 build -> add 60+50 -> 13 after 1 cycle.
